// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS-subset control unit: state encoding,
// opcode/funct values and the ALU code set understood by the downstream ALU.
package mc_pkg;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      EXEC   = 4'd2,
      MEM    = 4'd3,
      WB     = 4'd4,
      BRANCH = 4'd5,
      JUMP   = 4'd6,
      ERR    = 4'd7
   } state_t;

   localparam logic [5:0] OP_RTYPE    = 6'b000000;
   localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
   localparam logic [5:0] OP_ADDI     = 6'b001000;
   localparam logic [5:0] OP_ADDIU    = 6'b001001;
   localparam logic [5:0] OP_SLTI     = 6'b001010;
   localparam logic [5:0] OP_LW       = 6'b100011;
   localparam logic [5:0] OP_SW       = 6'b101011;
   localparam logic [5:0] OP_BEQ      = 6'b000100;
   localparam logic [5:0] OP_J        = 6'b000010;

   localparam logic [2:0] ALU_ARITH = 3'b000;
   localparam logic [2:0] ALU_SLT   = 3'b010;
   localparam logic [2:0] ALU_CNT   = 3'b100;
   localparam logic [2:0] ALU_ADDU  = 3'b101;
   localparam logic [2:0] ALU_ADDS  = 3'b110;

   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_CLZ = 6'b100000;
   localparam logic [5:0] FUNCT_CLO = 6'b100001;

   // Only CLZ/CLO are implemented in the SPECIAL2 space.
   function automatic logic isSpecial2Funct(input logic [5:0] funct);
      return (funct == FUNCT_CLZ) || (funct == FUNCT_CLO);
   endfunction

endpackage

// File: rtl/mc_mem_timer.sv
// Saturating wait counter for a pending memory request; flags a timeout on the
// cycle that would bring the count up to MEM_WAIT_MAX.
module mc_mem_timer #(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic waiting,
   output logic timeout
);

   localparam int CW = $clog2(MEM_WAIT_MAX + 1);
   localparam logic [CW-1:0] MAX_COUNT  = CW'(MEM_WAIT_MAX);
   localparam logic [CW-1:0] LAST_COUNT = CW'(MEM_WAIT_MAX - 1);

   logic [CW-1:0] waitCount;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         waitCount <= '0;
      end else if (clear) begin
         waitCount <= '0;
      end else if (waiting && (waitCount != MAX_COUNT)) begin
         waitCount <= waitCount + 1'b1;
      end
   end

   assign timeout = waiting && (waitCount >= LAST_COUNT);

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback and
// decodes the current state plus the latched opcode/funct into datapath controls.
module mc_control_unit
   import mc_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero_flag,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       i_or_d,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic [2:0] alu_code,
   output logic [5:0] alu_op,
   output logic [1:0] alu_src_b,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       illegal_op,
   output logic       bus_error,
   output logic [3:0] state_dbg
);

   state_t state;
   state_t nextState;
   logic   active;
   logic   errByTimeout;
   logic   timeoutErr;
   logic   timeout;
   logic   waiting;

   assign waiting = active && ((state == FETCH) || (state == MEM)) && !mem_ready;

   mc_mem_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) memTimer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (active && (nextState != state)),
      .waiting (waiting),
      .timeout (timeout)
   );

   // Next-state selection; a completed memory response always wins over a timeout.
   always_comb begin
      nextState  = state;
      timeoutErr = 1'b0;
      case (state)
         FETCH: begin
            if (mem_ready) begin
               nextState = DECODE;
            end else if (timeout) begin
               nextState  = ERR;
               timeoutErr = 1'b1;
            end
         end
         DECODE: begin
            if (opcode inside {OP_RTYPE, OP_SPECIAL2, OP_ADDI, OP_ADDIU, OP_SLTI, OP_LW, OP_SW})
               nextState = EXEC;
            else if (opcode == OP_BEQ)
               nextState = BRANCH;
            else if (opcode == OP_J)
               nextState = JUMP;
            else
               nextState = ERR;
         end
         EXEC: begin
            if ((opcode == OP_SPECIAL2) && !isSpecial2Funct(funct))
               nextState = ERR;
            else if ((opcode == OP_LW) || (opcode == OP_SW))
               nextState = MEM;
            else
               nextState = WB;
         end
         MEM: begin
            if (mem_ready) begin
               nextState = (opcode == OP_SW) ? FETCH : WB;
            end else if (timeout) begin
               nextState  = ERR;
               timeoutErr = 1'b1;
            end
         end
         default: nextState = FETCH;
      endcase
   end

   // The FSM holds in FETCH for one edge after reset release so no request is raised early.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= FETCH;
         active       <= 1'b0;
         errByTimeout <= 1'b0;
      end else if (!active) begin
         active <= 1'b1;
      end else begin
         state        <= nextState;
         errByTimeout <= timeoutErr;
      end
   end

   // Moore decode of state and IR fields; everything stays low until the FSM is active.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      alu_code   = ALU_ARITH;
      alu_op     = 6'b000000;
      alu_src_b  = 2'b00;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      illegal_op = 1'b0;
      bus_error  = 1'b0;
      if (active) begin
         case (state)
            FETCH: begin
               mem_req  = 1'b1;
               ir_write = mem_ready;
               pc_write = mem_ready;
            end
            EXEC: begin
               case (opcode)
                  OP_RTYPE: alu_op = funct;
                  OP_SPECIAL2: begin
                     if (isSpecial2Funct(funct)) begin
                        alu_code = ALU_CNT;
                        alu_op   = funct;
                     end
                  end
                  OP_ADDI: begin
                     alu_code  = ALU_ADDS;
                     alu_src_b = 2'b01;
                  end
                  OP_SLTI: begin
                     alu_code  = ALU_SLT;
                     alu_src_b = 2'b01;
                  end
                  OP_ADDIU, OP_LW, OP_SW: begin
                     alu_code  = ALU_ADDU;
                     alu_src_b = 2'b01;
                  end
                  default: ;
               endcase
            end
            MEM: begin
               mem_req = 1'b1;
               i_or_d  = 1'b1;
               mem_we  = (opcode == OP_SW);
            end
            WB: begin
               reg_write  = 1'b1;
               reg_dst    = (opcode == OP_RTYPE) || (opcode == OP_SPECIAL2);
               mem_to_reg = (opcode == OP_LW);
            end
            BRANCH: begin
               alu_op   = FUNCT_SUB;
               pc_src   = 2'b01;
               pc_write = zero_flag;
            end
            JUMP: begin
               pc_write = 1'b1;
               pc_src   = 2'b10;
            end
            ERR: begin
               bus_error  = errByTimeout;
               illegal_op = !errByTimeout;
            end
            default: ;
         endcase
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: each instruction is expanded into its expected
// per-cycle state path from the CPI rules, and every cycle's outputs are compared.
module tb_mc_control_unit;

   localparam int MAXW = 15;

   logic       clk;
   logic       rst_n;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zeroFlag;
   logic       memReady;
   logic       memReq, memWe, iOrD, irWrite, pcWrite;
   logic [1:0] pcSrc;
   logic [2:0] aluCode;
   logic [5:0] aluOp;
   logic [1:0] aluSrcB;
   logic       regWrite, regDst, memToReg, illegalOp, busError;
   logic [3:0] stateDbg;
   logic [26:0] dutVec;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      int   st;
      logic rdy;
      logic z;
      logic errTo;
   } step_t;

   mc_control_unit #(.MEM_WAIT_MAX(MAXW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .funct      (funct),
      .zero_flag  (zeroFlag),
      .mem_ready  (memReady),
      .mem_req    (memReq),
      .mem_we     (memWe),
      .i_or_d     (iOrD),
      .ir_write   (irWrite),
      .pc_write   (pcWrite),
      .pc_src     (pcSrc),
      .alu_code   (aluCode),
      .alu_op     (aluOp),
      .alu_src_b  (aluSrcB),
      .reg_write  (regWrite),
      .reg_dst    (regDst),
      .mem_to_reg (memToReg),
      .illegal_op (illegalOp),
      .bus_error  (busError),
      .state_dbg  (stateDbg)
   );

   assign dutVec = {memReq, memWe, iOrD, irWrite, pcWrite, pcSrc, aluCode, aluOp, aluSrcB,
                    regWrite, regDst, memToReg, illegalOp, busError, stateDbg};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Control values the instruction set table calls for in a given state.
   function automatic logic [26:0] specOut(input int st, input logic [5:0] op, input logic [5:0] fn,
                                           input logic rdy, input logic z, input logic errTo);
      logic       mReq = 0, mWe = 0, iod = 0, irW = 0, pcW = 0;
      logic [1:0] pSrc = 0, srcB = 0;
      logic [2:0] code = 0;
      logic [5:0] aop = 0;
      logic       rW = 0, rDst = 0, m2r = 0, ill = 0, berr = 0;
      case (st)
         0: begin mReq = 1; irW = rdy; pcW = rdy; end
         2: begin
            if (op == 6'b000000) aop = fn;
            else if (op == 6'b011100) begin code = 3'b100; aop = fn; end
            else if (op == 6'b001000) begin code = 3'b110; srcB = 2'b01; end
            else if (op == 6'b001001) begin code = 3'b101; srcB = 2'b01; end
            else if (op == 6'b001010) begin code = 3'b010; srcB = 2'b01; end
            else if (op == 6'b100011 || op == 6'b101011) begin code = 3'b101; srcB = 2'b01; end
         end
         3: begin mReq = 1; iod = 1; mWe = (op == 6'b101011); end
         4: begin rW = 1; rDst = (op == 6'b000000 || op == 6'b011100); m2r = (op == 6'b100011); end
         5: begin aop = 6'b100010; pSrc = 2'b01; pcW = z; end
         6: begin pcW = 1; pSrc = 2'b10; end
         7: begin berr = errTo; ill = !errTo; end
         default: ;
      endcase
      return {mReq, mWe, iod, irW, pcW, pSrc, code, aop, srcB, rW, rDst, m2r, ill, berr, 4'(st)};
   endfunction

   task automatic releaseReset();
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Expands one instruction into its state path, plays it and checks every cycle.
   task automatic runInstr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw, input logic z);
      step_t plan[$];
      logic [26:0] exp;
      logic [26:0] mask;
      bit    execClass;
      bit    badSpecial2;
      execClass   = op inside {6'b000000, 6'b011100, 6'b001000, 6'b001001, 6'b001010, 6'b100011, 6'b101011};
      badSpecial2 = (op == 6'b011100) && !(fn == 6'b100000 || fn == 6'b100001);
      for (int i = 0; i < fw && i < MAXW; i++) plan.push_back('{0, 1'b0, 1'($urandom), 1'b0});
      if (fw >= MAXW) begin
         plan.push_back('{7, 1'($urandom), 1'($urandom), 1'b1});
      end else begin
         plan.push_back('{0, 1'b1, 1'($urandom), 1'b0});
         plan.push_back('{1, 1'($urandom), 1'($urandom), 1'b0});
         if (op == 6'b000100) plan.push_back('{5, 1'($urandom), z, 1'b0});
         else if (op == 6'b000010) plan.push_back('{6, 1'($urandom), 1'($urandom), 1'b0});
         else if (!execClass) plan.push_back('{7, 1'($urandom), 1'($urandom), 1'b0});
         else begin
            plan.push_back('{2, 1'($urandom), 1'($urandom), 1'b0});
            if (badSpecial2) begin
               plan.push_back('{7, 1'($urandom), 1'($urandom), 1'b0});
            end else if (op == 6'b100011 || op == 6'b101011) begin
               for (int i = 0; i < mw && i < MAXW; i++) plan.push_back('{3, 1'b0, 1'($urandom), 1'b0});
               if (mw >= MAXW) plan.push_back('{7, 1'($urandom), 1'($urandom), 1'b1});
               else begin
                  plan.push_back('{3, 1'b1, 1'($urandom), 1'b0});
                  if (op == 6'b100011) plan.push_back('{4, 1'($urandom), 1'($urandom), 1'b0});
               end
            end else begin
               plan.push_back('{4, 1'($urandom), 1'($urandom), 1'b0});
            end
         end
      end
      opcode = op;
      funct  = fn;
      foreach (plan[k]) begin
         memReady = plan[k].rdy;
         zeroFlag = plan[k].z;
         #1;
         exp  = specOut(plan[k].st, op, fn, plan[k].rdy, plan[k].z, plan[k].errTo);
         mask = '1;
         if (badSpecial2 && plan[k].st == 2) mask[19:11] = '0;
         vectors++;
         if ((dutVec & mask) !== (exp & mask)) begin
            miscompares++;
            $display("[TB] FAIL %s cycle %0d: got %b, expected %b", name, k, dutVec, exp);
         end
         @(posedge clk);
         #1;
      end
      vectors++;
      if (stateDbg !== 4'd0) begin
         miscompares++;
         $display("[TB] FAIL %s returnFetch: state_dbg got %0d, expected 0", name, stateDbg);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; opcode = '0; funct = '0; zeroFlag = 0; memReady = 0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (dutVec !== '0) begin
         miscompares++;
         $display("[TB] FAIL resetHold: got %b, expected 0", dutVec);
      end
      #2 rst_n = 1'b1;
      #1;
      vectors++;
      if (dutVec !== '0) begin
         miscompares++;
         $display("[TB] FAIL releaseWait: got %b, expected 0", dutVec);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (dutVec !== specOut(0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0)) begin
         miscompares++;
         $display("[TB] FAIL firstFetch: got %b, expected %b", dutVec, specOut(0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0));
      end
      #1 rst_n = 1'b0;
      #1;
      vectors++;
      if (memReq !== 1'b0 || dutVec !== '0) begin
         miscompares++;
         $display("[TB] FAIL asyncDrop: got %b, expected 0", dutVec);
      end
      releaseReset();
      // Walk an SW into its MEM cycle, then reset while the write is being requested.
      opcode = 6'b101011; funct = 6'($urandom); memReady = 1'b1;
      @(posedge clk); #1 memReady = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      vectors++;
      if (dutVec !== specOut(3, 6'b101011, funct, 1'b0, zeroFlag, 1'b0)) begin
         miscompares++;
         $display("[TB] FAIL swMemBeforeReset: got %b, expected %b", dutVec, specOut(3, 6'b101011, funct, 1'b0, zeroFlag, 1'b0));
      end
      #1 rst_n = 1'b0;
      #1;
      vectors++;
      if (memWe !== 1'b0 || dutVec !== '0) begin
         miscompares++;
         $display("[TB] FAIL midWriteDrop: got %b, expected 0", dutVec);
      end
      releaseReset();
   endtask

   task automatic test_rtype();
      runInstr("rtypeAdd", 6'b000000, 6'b100000, 0, 0, 1'b0);
      runInstr("rtypeAddWait", 6'b000000, 6'b100000, 1, 0, 1'b0);
      runInstr("addi", 6'b001000, 6'($urandom), 0, 0, 1'b0);
      runInstr("addiu", 6'b001001, 6'($urandom), 2, 0, 1'b0);
      runInstr("slti", 6'b001010, 6'($urandom), 0, 0, 1'b0);
   endtask

   task automatic test_lw_sw();
      runInstr("lwWait3", 6'b100011, 6'($urandom), 0, 3, 1'b0);
      runInstr("swWait3", 6'b101011, 6'($urandom), 0, 3, 1'b0);
      runInstr("swNoWait", 6'b101011, 6'($urandom), 1, 0, 1'b0);
      runInstr("lwMaxWait", 6'b100011, 6'($urandom), 0, MAXW - 1, 1'b0);
      runInstr("swMemTimeout", 6'b101011, 6'($urandom), 0, MAXW, 1'b0);
   endtask

   task automatic test_beq();
      runInstr("beqTaken", 6'b000100, 6'($urandom), 0, 0, 1'b1);
      runInstr("beqNotTaken", 6'b000100, 6'($urandom), 0, 0, 1'b0);
      runInstr("jump", 6'b000010, 6'($urandom), 1, 0, 1'b0);
   endtask

   task automatic test_illegal_special2();
      runInstr("illegal3f", 6'b111111, 6'($urandom), 0, 0, 1'b0);
      runInstr("clo", 6'b011100, 6'b100001, 0, 0, 1'b0);
      runInstr("clz", 6'b011100, 6'b100000, 0, 0, 1'b0);
      runInstr("badSpecial2", 6'b011100, 6'b000010, 0, 0, 1'b0);
   endtask

   task automatic test_timeout();
      runInstr("fetchTimeout", 6'b000000, 6'b100000, MAXW, 0, 1'b0);
      runInstr("fetchAfterTimeout", 6'b000000, 6'b100000, MAXW - 1, 0, 1'b0);
   endtask

   task automatic test_random();
      logic [5:0] ops [12];
      ops = '{6'b000000, 6'b011100, 6'b001000, 6'b001001, 6'b001010, 6'b100011,
              6'b101011, 6'b000100, 6'b000010, 6'b111111, 6'b000001, 6'b000000};
      for (int n = 0; n < 80; n++) begin
         logic [5:0] op;
         logic [5:0] fn;
         int fw, mw;
         op = ops[$urandom_range(0, 11)];
         if (n % 13 == 12) op = 6'($urandom);
         fn = 6'($urandom);
         if (op == 6'b011100 && $urandom_range(0, 2) != 0) fn = $urandom_range(0, 1) ? 6'b100000 : 6'b100001;
         fw = ($urandom_range(0, 19) == 0) ? MAXW : $urandom_range(0, 3);
         mw = ($urandom_range(0, 19) == 0) ? MAXW : $urandom_range(0, 4);
         runInstr("random", op, fn, fw, mw, 1'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw_sw();
      test_beq();
      test_illegal_special2();
      test_timeout();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle control FSM for the MIPS-subset datapath, sitting directly upstream of the ALU.
- Decodes the latched instruction's opcode/funct and sequences the datapath through FETCH/DECODE/EXEC/MEM/WB.
- Drives the ALU's 3-bit code and 6-bit operation inputs, and consumes the ALU zero flag for BEQ.
- Talks to a unified instruction/data memory over a req/ready handshake with a bounded wait.

Parameters:
- MEM_WAIT_MAX, 15, max cycles `mem_req` may stay unanswered before `bus_error`; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instr[31:26] from IR.
- funct  in  6  instr[5:0] from IR.
- zero_flag  in  1  ALU zero flag.
- mem_ready  in  1  memory completion, sampled while `mem_req`=1.
- mem_req  out  1  memory access request.
- mem_we  out  1  write enable, valid with `mem_req`.
- i_or_d  out  1  address select: 0=PC, 1=ALU result register.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC.
- pc_src  out  2  00=PC+4, 01=branch target, 10=jump target.
- alu_code  out  3  ALU code.
- alu_op  out  6  ALU operation/funct.
- alu_src_b  out  2  00=rt, 01=sign-ext imm, 10=zero-ext imm.
- reg_write  out  1  register-file write.
- reg_dst  out  1  0=rt, 1=rd.
- mem_to_reg  out  1  0=ALU result, 1=memory data register.
- illegal_op  out  1  one-cycle pulse on undecodable instruction.
- bus_error  out  1  one-cycle pulse on memory timeout.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset (async, `rst_n`=0):
  - state=FETCH, wait counter=0.
  - All outputs 0 except `state_dbg`=FETCH.
  - Deassertion takes effect on the next `clk` edge.
  - Reset mid-access drops `mem_req` immediately; no write completes.
- Outputs are Moore (registered state, combinational decode of state + latched opcode/funct), except `ir_write`/`pc_write` in FETCH, which equal `mem_ready`.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, JUMP=6, ERR=7.
- FETCH:
  - Drives `mem_req`=1, `i_or_d`=0, `mem_we`=0.
  - On `mem_ready`: `ir_write`=`pc_write`=1, `pc_src`=00, next state DECODE.
  - Else the wait counter increments; when it reaches MEM_WAIT_MAX go to ERR.
- DECODE: one cycle; the counter clears. Next state by opcode:
  - 000000 (R-type), 011100 (SPECIAL2), 001000, 001001, 001010, 100011, 101011 -> EXEC.
  - 000100 -> BRANCH.
  - 000010 -> JUMP.
  - Anything else -> ERR with `illegal_op`=1.
- EXEC drives the ALU as follows:
  - R-type: `alu_code`=000, `alu_op`=funct, `alu_src_b`=00.
  - SPECIAL2 with funct 100000/100001: `alu_code`=100, `alu_op`=funct. Any other SPECIAL2 funct goes to ERR with `illegal_op`.
  - ADDI 001000: `alu_code`=110, `alu_src_b`=01.
  - ADDIU 001001: `alu_code`=101, `alu_src_b`=01.
  - SLTI 001010: `alu_code`=010, `alu_src_b`=01.
  - LW/SW: `alu_code`=101, `alu_src_b`=01, next state MEM.
  - All other EXEC instructions go to WB.
  - `alu_code`/`alu_op` are held stable for the whole EXEC cycle, so the ALU sees them before the result is captured.
- MEM:
  - Drives `mem_req`=1, `i_or_d`=1, `mem_we`=(opcode==101011).
  - On `mem_ready`: SW -> FETCH, LW -> WB.
  - Timeout handling is identical to FETCH.
- WB: `reg_write`=1 for one cycle, then FETCH.
  - `reg_dst`=1 for R-type/SPECIAL2, else 0.
  - `mem_to_reg`=1 only for LW.
- BRANCH:
  - `alu_code`=000, `alu_op`=100010 (subtract), `alu_src_b`=00, `pc_src`=01.
  - `pc_write`=`zero_flag`.
  - Next state FETCH.
- JUMP: `pc_write`=1, `pc_src`=10, next state FETCH.
- ERR: `bus_error`=1 if entered by timeout; pulse outputs last exactly one cycle. Next state FETCH; the PC is unchanged and the instruction is dropped.
- `mem_ready` outside FETCH/MEM is ignored.
- The wait counter is $clog2(MEM_WAIT_MAX+1) bits, saturating, and clears on every state change.
- CPI: R-type/ALU-imm 4, LW 5, SW 4, BEQ/J 3, each plus memory wait cycles.

Decomposition:
- Shared package (mc_pkg):
  - State enum.
  - Opcode constants: OP_RTYPE, OP_SPECIAL2, OP_ADDI, OP_ADDIU, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_J.
  - ALU code constants: ALU_ARITH=000, ALU_SLT=010, ALU_CNT=100, ALU_ADDU=101, ALU_ADDS=110.
  - FUNCT_SUB, FUNCT_CLZ, FUNCT_CLO.
- One sub-module, mc_mem_timer: saturating wait counter with a timeout output, reused by FETCH and MEM.
- The FSM and output decode stay in mc_control_unit.

Test Plan:
- Reset: hold `rst_n`=0 mid-FETCH with `mem_req`=1 -> `mem_req`=0 asynchronously; after release `state_dbg`=0 and all outputs 0.
- R-type ADD: opcode=000000, funct=100000, `mem_ready` 1 cycle after req -> EXEC shows `alu_code`=000, `alu_op`=100000; WB `reg_write`=1, `reg_dst`=1; 4 cycles total.
- LW with 3 wait cycles in MEM:
  - EXEC `alu_code`=101, `alu_src_b`=01.
  - MEM `i_or_d`=1, `mem_we`=0 held 4 cycles.
  - WB `mem_to_reg`=1.
  - SW variant: `mem_we`=1, returns to FETCH without WB.
- BEQ: `zero_flag`=1 -> `pc_write`=1, `pc_src`=01, `alu_op`=100010. Repeat with `zero_flag`=0 -> `pc_write`=0; both go to FETCH next.
- Illegal/SPECIAL2: opcode=111111 -> `illegal_op` single pulse, back to FETCH. SPECIAL2 funct=100001 -> `alu_code`=100, `alu_op`=100001.
- Timeout: MEM_WAIT_MAX=15, `mem_ready` never asserted -> `bus_error` pulses once after 15 FETCH cycles, then FETCH restarts with the counter at 0.
